sphere_pair_dispatcher: RTL and testbench

- Initiator/collector on the far side of the sphere-sphere collider core.
- Accepts sphere-pair jobs over a stb/ack handshake and presents held operands to the collider.
- Starts the collider by pulsing its active-low reset, waits for done with a timeout, and captures the contact geometry.
- Queues colliding results (ret=1) in a contact FIFO that downstream reads over a stb/ack interface.

---
 rtl/sphere_pair_dispatcher_pkg.sv | 44 ++++
 rtl/sphere_pair_dispatcher_contact_fifo.sv | 54 +++++
 rtl/sphere_pair_dispatcher.sv | 172 +++++++++++++++++
 tb/tb_sphere_pair_dispatcher.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sphere_pair_dispatcher_pkg.sv
// Shared widths, contact field layout, FSM state encoding and helpers for the
// sphere-pair dispatcher and its contact FIFO.
package sphere_pair_dispatcher_pkg;

  localparam int FLOAT_W   = 32;
  localparam int SPHERE_W  = 4 * FLOAT_W;
  localparam int CONTACT_W = 7 * FLOAT_W;
  localparam int GEOM_W    = 32;
  localparam int ENTRY_W   = CONTACT_W + 2 * GEOM_W;

  // Contact word is {cx, cy, cz, nx, ny, nz, depth}, cx in the MSBs.
  localparam int CT_DEPTH_LSB = 0;
  localparam int CT_NZ_LSB    = 1 * FLOAT_W;
  localparam int CT_NY_LSB    = 2 * FLOAT_W;
  localparam int CT_NX_LSB    = 3 * FLOAT_W;
  localparam int CT_CZ_LSB    = 4 * FLOAT_W;
  localparam int CT_CY_LSB    = 5 * FLOAT_W;
  localparam int CT_CX_LSB    = 6 * FLOAT_W;

  localparam logic [FLOAT_W-1:0] FP_ONE = 32'h3F800000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    EMIT   = 2'd3
  } state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_LAUNCH = LAUNCH;
  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_EMIT   = EMIT;

  function automatic logic [FLOAT_W-1:0] contact_depth(input logic [CONTACT_W-1:0] contact);
    return contact[CT_DEPTH_LSB +: FLOAT_W];
  endfunction

  // Bit-pattern compare is order-preserving only for non-negative floats.
  function automatic logic depth_passes(input logic [FLOAT_W-1:0] depth,
                                        input logic [FLOAT_W-1:0] min_depth);
    return !depth[FLOAT_W-1] && (depth[FLOAT_W-2:0] >= min_depth[FLOAT_W-2:0]);
  endfunction

endpackage

// File: rtl/sphere_pair_dispatcher_contact_fifo.sv
// Synchronous FIFO for contact records; head is always the oldest entry and
// a pop and push may share a cycle even when full.
module contact_fifo
  import sphere_pair_dispatcher_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sphere_pair_dispatcher.sv
// Feeds sphere pairs to the collider, times it out, and queues colliding
// contacts. Optional depth filter: define CONTACT_DEPTH_FILTER_EN.
//
// Handshakes: a job transfers on a rising clk edge where in_stb=1 and
// in_ack=1 (in_ack is combinational, IDLE only); a FIFO entry leaves on an
// edge where out_stb=1 and out_ack=1. in_stb/in_sphere*/in_g* must be held
// until acknowledged.
module sphere_pair_dispatcher
  import sphere_pair_dispatcher_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 4,
  parameter int          START_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] MIN_DEPTH      = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SPHERE_W-1:0]  in_sphere1,
  input  logic [SPHERE_W-1:0]  in_sphere2,
  input  logic [GEOM_W-1:0]    in_g1,
  input  logic [GEOM_W-1:0]    in_g2,
  input  logic                 in_stb,
  output logic                 in_ack,
  output logic [SPHERE_W-1:0]  col_sphere1,
  output logic [SPHERE_W-1:0]  col_sphere2,
  output logic                 col_rst,
  input  logic                 col_done,
  input  logic                 col_ret,
  input  logic [CONTACT_W-1:0] col_contact,
  output logic [CONTACT_W-1:0] out_contact,
  output logic [GEOM_W-1:0]    out_g1,
  output logic [GEOM_W-1:0]    out_g2,
  output logic                 out_stb,
  input  logic                 out_ack,
  output logic                 busy,
  output logic [15:0]          pairs_tested,
  output logic [15:0]          contacts_found,
  output logic [7:0]           timeouts,
  output logic [1:0]           dbg_state
);

`ifdef CONTACT_DEPTH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(START_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state;
  logic [SC_W-1:0]      r_start_cnt;
  logic [TO_W-1:0]      r_to_cnt;
  logic [SPHERE_W-1:0]  r_sphere1;
  logic [SPHERE_W-1:0]  r_sphere2;
  logic [GEOM_W-1:0]    r_g1;
  logic [GEOM_W-1:0]    r_g2;
  logic                 r_ret;
  logic [CONTACT_W-1:0] r_contact;
  logic [15:0]          r_pairs;
  logic [15:0]          r_contacts;
  logic [7:0]           r_timeouts;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_can_push;
  logic                 w_depth_ok;
  logic                 w_keep;
  logic [ENTRY_W-1:0]   w_head;

  assign w_depth_ok = depth_passes(contact_depth(r_contact), MIN_DEPTH);
  assign w_keep     = r_ret && (w_depth_ok || !FILTER_ON);
  assign w_pop      = !w_empty && out_ack;
  // A same-cycle pop frees the slot the push needs.
  assign w_can_push = !w_full || w_pop;
  assign w_push     = (r_state == ST_EMIT) && w_keep && w_can_push;

  assign in_ack      = (r_state == ST_IDLE) && in_stb;
  assign col_rst     = (r_state == ST_RUN);
  assign busy        = (r_state != ST_IDLE);
  assign dbg_state   = r_state;
  assign col_sphere1 = r_sphere1;
  assign col_sphere2 = r_sphere2;

  assign out_stb        = !w_empty;
  assign out_contact    = w_head[ENTRY_W-1 -: CONTACT_W];
  assign out_g1         = w_head[2*GEOM_W-1 -: GEOM_W];
  assign out_g2         = w_head[GEOM_W-1:0];
  assign pairs_tested   = r_pairs;
  assign contacts_found = r_contacts;
  assign timeouts       = r_timeouts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_start_cnt <= '0;
      r_to_cnt    <= '0;
      r_sphere1   <= '0;
      r_sphere2   <= '0;
      r_g1        <= '0;
      r_g2        <= '0;
      r_ret       <= 1'b0;
      r_contact   <= '0;
      r_pairs     <= '0;
      r_contacts  <= '0;
      r_timeouts  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_stb) begin
            r_sphere1   <= in_sphere1;
            r_sphere2   <= in_sphere2;
            r_g1        <= in_g1;
            r_g2        <= in_g2;
            r_start_cnt <= '0;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (r_start_cnt == SC_LAST) begin
            r_to_cnt <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_start_cnt <= r_start_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          // Done is checked first so it wins over a coincident timeout.
          if (col_done) begin
            r_ret     <= col_ret;
            r_contact <= col_contact;
            r_pairs   <= (&r_pairs) ? r_pairs : r_pairs + 1'b1;
            r_state   <= ST_EMIT;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeouts <= (&r_timeouts) ? r_timeouts : r_timeouts + 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_EMIT: begin
          if (!w_keep) begin
            r_state <= ST_IDLE;
          end else if (w_can_push) begin
            r_contacts <= (&r_contacts) ? r_contacts : r_contacts + 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  contact_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (w_push),
    .push_data ({r_contact, r_g1, r_g2}),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_sphere_pair_dispatcher.sv
// Directed bench for sphere_pair_dispatcher: job table plus hand sequences for
// FIFO-full stall and mid-job reset, with a behavioural collider model.
module tb_sphere_pair_dispatcher;
  import sphere_pair_dispatcher_pkg::*;

  localparam int          FIFO_DEPTH     = 4;
  localparam int          START_CYCLES   = 2;
  localparam int          TIMEOUT_CYCLES = 1024;
  localparam logic [31:0] MIN_DEPTH      = 32'h3E800000;  // 0.25

`ifdef CONTACT_DEPTH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  localparam logic [31:0] F_0    = 32'h00000000;
  localparam logic [31:0] F_0P1  = 32'h3DCCCCCD;
  localparam logic [31:0] F_HALF = 32'h3F000000;
  localparam logic [31:0] F_NEG  = 32'hBF000000;
  localparam logic [31:0] F_1P5  = 32'h3FC00000;
  localparam logic [31:0] F_5    = 32'h40A00000;

  typedef struct {
    logic [127:0] s1;
    logic [127:0] s2;
    logic [31:0]  g1;
    logic [31:0]  g2;
    logic         ret;
    logic [31:0]  depth;
    int           lat;
    bit           never;
  } job_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_sphere1 = '0;
  logic [127:0] in_sphere2 = '0;
  logic [31:0]  in_g1 = '0;
  logic [31:0]  in_g2 = '0;
  logic         in_stb = 1'b0;
  logic         in_ack;
  logic [127:0] col_sphere1;
  logic [127:0] col_sphere2;
  logic         col_rst;
  logic         col_done = 1'b0;
  logic         col_ret;
  logic [223:0] col_contact;
  logic [223:0] out_contact;
  logic [31:0]  out_g1;
  logic [31:0]  out_g2;
  logic         out_stb;
  logic         out_ack = 1'b0;
  logic         busy;
  logic [15:0]  pairs_tested;
  logic [15:0]  contacts_found;
  logic [7:0]   timeouts;
  logic [1:0]   dbg_state;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           ack_cnt = 0;
  int           exp_pairs = 0;
  int           exp_contacts = 0;
  int           exp_timeouts = 0;
  logic [287:0] exp_q[$];

  // Collider model
  int           m_lat = 1;
  bit           m_never = 1'b0;
  logic         m_ret = 1'b0;
  logic [223:0] m_contact = '0;
  int           m_cnt = 0;

  assign col_ret     = m_ret;
  assign col_contact = m_contact;

  sphere_pair_dispatcher #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .START_CYCLES   (START_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MIN_DEPTH      (MIN_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_sphere1     (in_sphere1),
    .in_sphere2     (in_sphere2),
    .in_g1          (in_g1),
    .in_g2          (in_g2),
    .in_stb         (in_stb),
    .in_ack         (in_ack),
    .col_sphere1    (col_sphere1),
    .col_sphere2    (col_sphere2),
    .col_rst        (col_rst),
    .col_done       (col_done),
    .col_ret        (col_ret),
    .col_contact    (col_contact),
    .out_contact    (out_contact),
    .out_g1         (out_g1),
    .out_g2         (out_g2),
    .out_stb        (out_stb),
    .out_ack        (out_ack),
    .busy           (busy),
    .pairs_tested   (pairs_tested),
    .contacts_found (contacts_found),
    .timeouts       (timeouts),
    .dbg_state      (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Collider: done rises after m_lat edges with col_rst high, cleared when low.
  always @(posedge clk) begin
    if (col_rst !== 1'b1) begin
      m_cnt    <= 0;
      col_done <= 1'b0;
    end else begin
      m_cnt    <= m_cnt + 1;
      col_done <= !m_never && (m_cnt + 1 == m_lat);
    end
  end

  // Acceptance monitor, sampled mid-cycle.
  always begin
    @(negedge clk);
    #2;
    if (in_ack === 1'b1) ack_cnt++;
  end

  function automatic logic [127:0] mk_sphere(input logic [31:0] x, input logic [31:0] r);
    return {x, F_0, F_0, r};
  endfunction

  function automatic logic [223:0] mk_contact(input logic [31:0] cx, input logic [31:0] depth);
    logic [223:0] c;
    c = '0;
    c[CT_CX_LSB +: 32]    = cx;
    c[CT_NX_LSB +: 32]    = FP_ONE;
    c[CT_DEPTH_LSB +: 32] = depth;
    return c;
  endfunction

  function automatic bit push_expected(input job_t j);
    return !j.never && j.ret &&
           (!FILT || (!j.depth[31] && (j.depth[30:0] >= MIN_DEPTH[30:0])));
  endfunction

  task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic start_job(input job_t j, output bit got);
    m_lat     = j.lat;
    m_never   = j.never;
    m_ret     = j.ret;
    m_contact = mk_contact(j.g1, j.depth);
    @(negedge clk);
    in_sphere1 = j.s1;
    in_sphere2 = j.s2;
    in_g1      = j.g1;
    in_g2      = j.g2;
    in_stb     = 1'b1;
    got        = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (in_ack === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    in_stb = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int launch_n, output int run_n, output bit ok);
    launch_n = 0;
    run_n    = 0;
    ok       = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (col_rst === 1'b1) run_n++;
      else if (run_n == 0) launch_n++;
      @(negedge clk);
    end
  endtask

  task automatic pop_check(input string name);
    logic [287:0] exp;
    check({name, "_stb"}, out_stb, 1'b1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_nonempty"}, 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check({name, "_data"}, {out_contact, out_g1, out_g2}, exp);
    end
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  task automatic check_counters(input string name);
    check({name, "_pairs"},    pairs_tested,   exp_pairs[15:0]);
    check({name, "_contacts"}, contacts_found, exp_contacts[15:0]);
    check({name, "_timeouts"}, timeouts,       exp_timeouts[7:0]);
  endtask

  job_t vec [8];

  initial begin
    bit   got;
    bit   ok;
    int   launch_n;
    int   run_n;
    int   a0;
    job_t j;
    string nm;

    vec[0] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_1P5, FP_ONE), 32'h11, 32'h22, 1'b1, F_HALF, 20, 1'b0};
    vec[1] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_5,   FP_ONE), 32'h33, 32'h44, 1'b0, F_0,    12, 1'b0};
    vec[2] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_5,   FP_ONE), 32'h55, 32'h66, 1'b0, F_0,     1, 1'b1};
    vec[3] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_1P5, FP_ONE), 32'h77, 32'h88, 1'b1, F_HALF,  1, 1'b0};
    vec[4] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_1P5, FP_ONE), 32'h99, 32'hAA, 1'b1, F_0P1,   5, 1'b0};
    vec[5] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_1P5, FP_ONE), 32'hBB, 32'hCC, 1'b1, F_HALF,  7, 1'b0};
    vec[6] = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_1P5, FP_ONE), 32'hDD, 32'hEE, 1'b1, F_NEG,   2, 1'b0};
    vec[7] = '{mk_sphere(F_1P5, FP_ONE), mk_sphere(F_0, FP_ONE), 32'h12, 32'h34, 1'b0, F_HALF,  3, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ack",   in_ack,      1'b0);
    check("rst_col_rst",  col_rst,     1'b0);
    check("rst_out_stb",  out_stb,     1'b0);
    check("rst_busy",     busy,        1'b0);
    check("rst_state",    dbg_state,   ST_IDLE);
    check("rst_contact",  out_contact, '0);
    check("rst_out_g",    {out_g1, out_g2}, '0);
    check("rst_col_sph",  {col_sphere1, col_sphere2}, '0);
    check_counters("rst");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven jobs
    for (int i = 0; i < 8; i++) begin
      j  = vec[i];
      a0 = ack_cnt;
      start_job(j, got);
      check($sformatf("v%0d_ack_seen", i), got, 1'b1);
      check($sformatf("v%0d_col_sph1", i), col_sphere1, j.s1);
      check($sformatf("v%0d_col_sph2", i), col_sphere2, j.s2);
      wait_done(TIMEOUT_CYCLES + 200, launch_n, run_n, ok);
      check($sformatf("v%0d_done", i), ok, 1'b1);
      check($sformatf("v%0d_ack_pulses", i), ack_cnt - a0, 1);
      check($sformatf("v%0d_launch", i), launch_n, START_CYCLES);
      check($sformatf("v%0d_run", i), run_n, j.never ? TIMEOUT_CYCLES : j.lat + 1);
      if (j.never) exp_timeouts++;
      else exp_pairs++;
      if (push_expected(j)) begin
        exp_contacts++;
        exp_q.push_back({mk_contact(j.g1, j.depth), j.g1, j.g2});
      end
      check_counters($sformatf("v%0d", i));
      while (exp_q.size() != 0) pop_check($sformatf("v%0d_pop", i));
      check($sformatf("v%0d_empty", i), out_stb, 1'b0);
    end

    // FIFO full: four fill, fifth stalls in EMIT until a pop.
    for (int k = 0; k < 5; k++) begin
      j = '{mk_sphere(F_0, FP_ONE), mk_sphere(F_1P5, FP_ONE),
            32'h100 + k, 32'h200 + k, 1'b1, F_HALF, 3 + k, 1'b0};
      start_job(j, got);
      nm = $sformatf("full%0d", k);
      check({nm, "_ack_seen"}, got, 1'b1);
      exp_pairs++;
      if (k < 4) begin
        wait_done(200, launch_n, run_n, ok);
        check({nm, "_done"}, ok, 1'b1);
        exp_contacts++;
        exp_q.push_back({mk_contact(j.g1, j.depth), j.g1, j.g2});
      end else begin
        repeat (20) @(negedge clk);
        check("full_stall_busy",  busy,      1'b1);
        check("full_stall_state", dbg_state, ST_EMIT);
        check_counters("full_stall");
        a0     = ack_cnt;
        in_stb = 1'b1;
        repeat (3) @(negedge clk);
        in_stb = 1'b0;
        check("full_stall_no_ack", ack_cnt - a0, 0);
        pop_check("full_pop0");
        check("full_after_pop_busy", busy, 1'b0);
        exp_contacts++;
        exp_q.push_back({mk_contact(j.g1, j.depth), j.g1, j.g2});
        check_counters("full_after_pop");
      end
    end
    for (int k = 0; k < 4; k++) pop_check($sformatf("full_drain%0d", k));
    check("full_drained", out_stb, 1'b0);

    // Mid-RUN reset with an entry queued.
    start_job(vec[0], got);
    wait_done(200, launch_n, run_n, ok);
    check("pre_rst_stb", out_stb, 1'b1);
    j = vec[2];
    start_job(j, got);
    for (int i = 0; i < 50 && col_rst !== 1'b1; i++) @(negedge clk);
    check("mid_run_col_rst", col_rst, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_col_rst", col_rst, 1'b0);
    check("mid_rst_busy",    busy,    1'b0);
    check("mid_rst_out_stb", out_stb, 1'b0);
    exp_q.delete();
    exp_pairs    = 0;
    exp_contacts = 0;
    exp_timeouts = 0;
    check_counters("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Recovery after reset.
    j = vec[5];
    start_job(j, got);
    check("recov_ack_seen", got, 1'b1);
    wait_done(200, launch_n, run_n, ok);
    check("recov_done", ok, 1'b1);
    exp_pairs++;
    exp_contacts++;
    exp_q.push_back({mk_contact(j.g1, j.depth), j.g1, j.g2});
    check_counters("recov");
    pop_check("recov_pop");
    check("recov_empty", out_stb, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
